reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order commit queue that sits downstream of the BCU and of the ALU/MEM CDB.
- Allocates ROB ids at dispatch and collects results from the CDB (ALU, MEM) and the BCU.
- Retires at most one entry per cycle to the register file or the store path.
- Raises a one-cycle flush on branch mispredict that resets every reservation station and the decoder.

Parameters:
- ROB_ID_WIDTH, 4: width of a ROB id. Id 0 means "none/invalid".
- DEPTH, 15: entry count, equal to 2^ROB_ID_WIDTH-1. Valid ids are 1..DEPTH.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- dispatch_valid  in  1  allocate an entry this cycle.
- dispatch_type  in  2  0=REG, 1=BRANCH, 2=STORE, 3=reserved (treated as REG).
- dispatch_rd  in  5  destination register (REG only).
- dispatch_pred_taken  in  1  predicted direction (BRANCH only).
- dispatch_ready  in  1  entry is complete at dispatch (e.g. LUI/JAL link value).
- dispatch_value  in  32  value when dispatch_ready=1.
- dispatch_id  out  ROB_ID_WIDTH  id that the next accepted dispatch receives (tail).
- has_no_vacancy  out  1  ROB full; combinational from registered count.
- query_j_id, query_k_id  in  ROB_ID_WIDTH  operand lookup ids.
- query_j_ready, query_k_ready  out  1  entry busy and result present; combinational.
- query_j_value, query_k_value  out  32  that entry's value.
- cdb_alu_rob_id  in  ROB_ID_WIDTH;  cdb_alu_value  in  32.
- cdb_mem_rob_id  in  ROB_ID_WIDTH;  cdb_mem_value  in  32.
- bcu_rob_id  in  ROB_ID_WIDTH;  bcu_taken  in  1;  bcu_value  in  32  resolved next PC.
- commit_reg_valid  out  1;  commit_rd  out  5;  commit_value  out  32;  commit_rob_id  out  ROB_ID_WIDTH.
- commit_store_valid  out  1  the store at the head may write memory.
- flush_out  out  1;  flush_pc  out  32.

Behaviour:
- Reset (async, rst_in=1):
  - head=tail=1, count=0, all busy/ready cleared.
  - Every registered output is 0: commit_*, commit_store_valid, flush_out, flush_pc.
- Ids:
  - head/tail advance 1→2→…→DEPTH→1. Id 0 is never allocated.
  - A writeback with id 0 is ignored.
- Dispatch:
  - Accepted iff dispatch_valid && !has_no_vacancy && !flush_out.
  - On accept: entry[tail] is written (busy=1, ready=dispatch_ready, value), tail advances, count+1.
  - A dispatch while full is dropped with no state change.
  - has_no_vacancy uses the registered count, so a same-cycle commit does not free a slot for that cycle's dispatch.
- Writeback (all three sources may fire the same cycle on distinct ids):
  - Only applies if the target entry is busy and not yet ready. It sets ready=1 and value.
  - BCU writeback also stores taken.
  - If ALU and MEM name the same id, ALU wins.
- Query:
  - ready/value reflect registered state only; same-cycle writebacks are not forwarded.
  - The RS input muxes handle CDB bypass.
- Commit: evaluated each cycle on registered state when entry[head] is busy and ready.
  - REG: commit_reg_valid=1, commit_rd, commit_value, commit_rob_id=head, registered (1-cycle latency).
  - STORE: commit_store_valid=1 and commit_rob_id=head.
  - BRANCH, taken==pred_taken: retires silently.
  - BRANCH, taken!=pred_taken: flush_out=1 and flush_pc=value on the next edge. All other commit outputs are 0 that cycle.
  - Every commit frees the entry, advances head, and decrements count. Simultaneous dispatch+commit leaves count unchanged.
  - Non-commit cycles: every commit output and flush_out is 0 (pulses).
- Flush:
  - On the edge after flush_out is asserted (flush_out already 1), all entries clear and head=tail=1, count=0.
  - No commit or dispatch takes place in that cycle.
  - flush_out then returns to 0.
- Reset asserted mid-flush or mid-commit overrides everything immediately.

Optional Feature:
- Macro ROB_PERF_COUNTERS_EN.
- When defined, two outputs are added, both 0 on reset and counting up with 32-bit wrap:
  - perf_commit_count (32): +1 per retired entry.
  - perf_mispredict_count (32): +1 per flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, dispatch REG rd=5 not ready, then the ALU writes id 1 with 0x1234 → next cycle commit_reg_valid=1, commit_rd=5, commit_value=0x1234, commit_rob_id=1.
- Dispatch 15 unready entries → has_no_vacancy=1. A 16th dispatch is dropped. Complete id 1 → commit, slot freed; the next dispatch gets id 1 (wrap).
- BRANCH pred_taken=0 at id 1, BCU id 1 taken=1 value=0x80 → flush_out=1, flush_pc=0x80 for one cycle. The next cycle dispatch_id=1 and has_no_vacancy=0.
- Ids 1 and 2 outstanding; id 2 completes first → no commit until id 1 completes, then ids 1 and 2 retire in consecutive cycles.
- ALU and MEM both target id 3 in one cycle with 0xA / 0xB → entry value 0xA. The query for id 3 shows ready=0 that cycle and ready=1 with value 0xA the next.
- Assert rst_in mid-stream with 3 entries pending → all outputs 0 immediately, dispatch_id=1.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order commit queue fed by dispatch, the ALU/MEM CDB and the BCU.
// Define ROB_PERF_COUNTERS_EN to add the perf_commit_count / perf_mispredict_count outputs.
module reorder_buffer #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int DEPTH        = 15
) (
    input  logic                    clk_in,
    input  logic                    rst_in,

    input  logic                    dispatch_valid,
    input  logic [1:0]              dispatch_type,
    input  logic [4:0]              dispatch_rd,
    input  logic                    dispatch_pred_taken,
    input  logic                    dispatch_ready,
    input  logic [31:0]             dispatch_value,
    output logic [ROB_ID_WIDTH-1:0] dispatch_id,
    output logic                    has_no_vacancy,

    input  logic [ROB_ID_WIDTH-1:0] query_j_id,
    input  logic [ROB_ID_WIDTH-1:0] query_k_id,
    output logic                    query_j_ready,
    output logic                    query_k_ready,
    output logic [31:0]             query_j_value,
    output logic [31:0]             query_k_value,

    input  logic [ROB_ID_WIDTH-1:0] cdb_alu_rob_id,
    input  logic [31:0]             cdb_alu_value,
    input  logic [ROB_ID_WIDTH-1:0] cdb_mem_rob_id,
    input  logic [31:0]             cdb_mem_value,
    input  logic [ROB_ID_WIDTH-1:0] bcu_rob_id,
    input  logic                    bcu_taken,
    input  logic [31:0]             bcu_value,

    output logic                    commit_reg_valid,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic [ROB_ID_WIDTH-1:0] commit_rob_id,
    output logic                    commit_store_valid,
    output logic                    flush_out,
    output logic [31:0]             flush_pc
`ifdef ROB_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perf_commit_count,
    output logic [31:0]             perf_mispredict_count
`endif
);

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_RSVD   = 2'd3
    } kind_t;

    localparam logic [ROB_ID_WIDTH-1:0] FIRST_ID = ROB_ID_WIDTH'(1);
    localparam logic [ROB_ID_WIDTH-1:0] LAST_ID  = ROB_ID_WIDTH'(DEPTH);

    // Slot 0 exists only so an id can index the arrays directly; it is never marked busy.
    logic [DEPTH:0]            busy;
    logic [DEPTH:0]            ready;
    logic [DEPTH:0]            taken_q;
    logic [DEPTH:0]            pred_q;
    kind_t                     kind_q  [0:DEPTH];
    logic [4:0]                rd_q    [0:DEPTH];
    logic [31:0]               value_q [0:DEPTH];

    logic [ROB_ID_WIDTH-1:0]   head;
    logic [ROB_ID_WIDTH-1:0]   tail;
    logic [ROB_ID_WIDTH-1:0]   count;

    kind_t                     head_kind;
    logic                      retire;
    logic                      head_is_reg;
    logic                      head_is_store;
    logic                      head_mispredict;
    logic                      accept;
    logic                      alu_we;
    logic                      mem_we;
    logic                      bcu_we;

    function automatic logic [ROB_ID_WIDTH-1:0] next_id(input logic [ROB_ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? FIRST_ID : id + 1'b1;
    endfunction

    // Dispatch handshake: a dispatch is taken on the edge where dispatch_valid is high,
    // has_no_vacancy is low and no flush is in progress; otherwise it is silently dropped.
    always_comb begin
        has_no_vacancy  = (count == LAST_ID);
        dispatch_id     = tail;
        head_kind       = kind_q[head];
        retire          = busy[head] && ready[head] && !flush_out;
        head_is_reg     = (head_kind == KIND_REG) || (head_kind == KIND_RSVD);
        head_is_store   = (head_kind == KIND_STORE);
        head_mispredict = (head_kind == KIND_BRANCH) && (taken_q[head] != pred_q[head]);
        accept          = dispatch_valid && !has_no_vacancy && !flush_out;
        alu_we          = !flush_out && (cdb_alu_rob_id != '0)
                          && busy[cdb_alu_rob_id] && !ready[cdb_alu_rob_id];
        mem_we          = !flush_out && (cdb_mem_rob_id != '0)
                          && busy[cdb_mem_rob_id] && !ready[cdb_mem_rob_id]
                          && !(alu_we && (cdb_alu_rob_id == cdb_mem_rob_id));
        bcu_we          = !flush_out && (bcu_rob_id != '0)
                          && busy[bcu_rob_id] && !ready[bcu_rob_id];
    end

    // Operand lookups see registered state only; the reservation stations bypass the CDB.
    always_comb begin
        query_j_ready = busy[query_j_id] && ready[query_j_id];
        query_k_ready = busy[query_k_id] && ready[query_k_id];
        query_j_value = value_q[query_j_id];
        query_k_value = value_q[query_k_id];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head               <= FIRST_ID;
            tail               <= FIRST_ID;
            count              <= '0;
            busy               <= '0;
            ready              <= '0;
            commit_reg_valid   <= 1'b0;
            commit_rd          <= '0;
            commit_value       <= '0;
            commit_rob_id      <= '0;
            commit_store_valid <= 1'b0;
            flush_out          <= 1'b0;
            flush_pc           <= '0;
        end else begin
            commit_reg_valid   <= 1'b0;
            commit_rd          <= '0;
            commit_value       <= '0;
            commit_rob_id      <= '0;
            commit_store_valid <= 1'b0;
            flush_out          <= 1'b0;
            flush_pc           <= '0;
            if (flush_out) begin
                head  <= FIRST_ID;
                tail  <= FIRST_ID;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (bcu_we) ready[bcu_rob_id]     <= 1'b1;
                if (mem_we) ready[cdb_mem_rob_id] <= 1'b1;
                if (alu_we) ready[cdb_alu_rob_id] <= 1'b1;
                if (accept) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= dispatch_ready;
                    tail        <= next_id(tail);
                end
                if (retire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= next_id(head);
                    if (head_is_reg) begin
                        commit_reg_valid <= 1'b1;
                        commit_rd        <= rd_q[head];
                        commit_value     <= value_q[head];
                        commit_rob_id    <= head;
                    end else if (head_is_store) begin
                        commit_store_valid <= 1'b1;
                        commit_rob_id      <= head;
                    end else if (head_mispredict) begin
                        flush_out <= 1'b1;
                        flush_pc  <= value_q[head];
                    end
                end
                case ({accept, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload needs no reset: it is only read while the matching busy bit is set.
    // Writes are ordered so that ALU overrides MEM on a shared id.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            kind_q[tail]  <= kind_t'(dispatch_type);
            rd_q[tail]    <= dispatch_rd;
            pred_q[tail]  <= dispatch_pred_taken;
            taken_q[tail] <= dispatch_pred_taken;
            value_q[tail] <= dispatch_value;
        end
        if (bcu_we) begin
            value_q[bcu_rob_id] <= bcu_value;
            taken_q[bcu_rob_id] <= bcu_taken;
        end
        if (mem_we) value_q[cdb_mem_rob_id] <= cdb_mem_value;
        if (alu_we) value_q[cdb_alu_rob_id] <= cdb_alu_value;
    end

`ifdef ROB_PERF_COUNTERS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_commit_count     <= '0;
            perf_mispredict_count <= '0;
        end else begin
            if (retire) perf_commit_count <= perf_commit_count + 32'd1;
            if (retire && head_mispredict) perf_mispredict_count <= perf_mispredict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model checked every cycle, plus directed scenarios.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        dispatch_valid;
    logic [1:0]  dispatch_type;
    logic [4:0]  dispatch_rd;
    logic        dispatch_pred_taken;
    logic        dispatch_ready;
    logic [31:0] dispatch_value;
    logic [3:0]  dispatch_id;
    logic        has_no_vacancy;
    logic [3:0]  query_j_id, query_k_id;
    logic        query_j_ready, query_k_ready;
    logic [31:0] query_j_value, query_k_value;
    logic [3:0]  cdb_alu_rob_id, cdb_mem_rob_id, bcu_rob_id;
    logic [31:0] cdb_alu_value, cdb_mem_value, bcu_value;
    logic        bcu_taken;
    logic        commit_reg_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_rob_id;
    logic        commit_store_valid;
    logic        flush_out;
    logic [31:0] flush_pc;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .dispatch_valid(dispatch_valid), .dispatch_type(dispatch_type),
        .dispatch_rd(dispatch_rd), .dispatch_pred_taken(dispatch_pred_taken),
        .dispatch_ready(dispatch_ready), .dispatch_value(dispatch_value),
        .dispatch_id(dispatch_id), .has_no_vacancy(has_no_vacancy),
        .query_j_id(query_j_id), .query_k_id(query_k_id),
        .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
        .query_j_value(query_j_value), .query_k_value(query_k_value),
        .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
        .cdb_mem_rob_id(cdb_mem_rob_id), .cdb_mem_value(cdb_mem_value),
        .bcu_rob_id(bcu_rob_id), .bcu_taken(bcu_taken), .bcu_value(bcu_value),
        .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_rob_id(commit_rob_id),
        .commit_store_valid(commit_store_valid),
        .flush_out(flush_out), .flush_pc(flush_pc)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // reference model: pending entries oldest first
    typedef struct {
        logic [3:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred;
        logic        rdy;
        logic [31:0] val;
        logic        tkn;
    } ent_t;

    ent_t        exp_q[$];
    logic [3:0]  m_tail     = 4'd1;
    logic        m_flush    = 1'b0;
    logic [31:0] m_flush_pc = '0;
    logic        m_reg_v    = 1'b0;
    logic        m_store_v  = 1'b0;
    logic [4:0]  m_rd       = '0;
    logic [31:0] m_val      = '0;
    logic [3:0]  m_rid      = '0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_tail = 4'd1; m_flush = 1'b0; m_flush_pc = '0;
        m_reg_v = 1'b0; m_store_v = 1'b0; m_rd = '0; m_val = '0; m_rid = '0;
    endtask

    task automatic wb(input logic [3:0] id, input logic [31:0] v, input logic is_bcu, input logic t);
        if (id == 4'd0) return;
        foreach (exp_q[i]) begin
            if (exp_q[i].id == id && !exp_q[i].rdy) begin
                exp_q[i].rdy = 1'b1;
                exp_q[i].val = v;
                if (is_bcu) exp_q[i].tkn = t;
            end
        end
    endtask

    task automatic model_step();
        logic flushing;
        logic full;
        ent_t e;
        flushing = m_flush;
        full     = (exp_q.size() == 15);
        m_reg_v = 1'b0; m_store_v = 1'b0; m_rd = '0; m_val = '0; m_rid = '0; m_flush = 1'b0;
        if (flushing) begin
            exp_q.delete();
            m_tail = 4'd1;
            return;
        end
        if (exp_q.size() > 0 && exp_q[0].rdy) begin
            e = exp_q.pop_front();
            if (e.kind == 2'd1) begin
                if (e.tkn != e.pred) begin
                    m_flush    = 1'b1;
                    m_flush_pc = e.val;
                end
            end else if (e.kind == 2'd2) begin
                m_store_v = 1'b1;
                m_rid     = e.id;
            end else begin
                m_reg_v = 1'b1; m_rd = e.rd; m_val = e.val; m_rid = e.id;
            end
        end
        // ALU applied first: a MEM write to the same id then finds it already complete
        wb(cdb_alu_rob_id, cdb_alu_value, 1'b0, 1'b0);
        wb(cdb_mem_rob_id, cdb_mem_value, 1'b0, 1'b0);
        wb(bcu_rob_id, bcu_value, 1'b1, bcu_taken);
        if (dispatch_valid && !full) begin
            e.id = m_tail; e.kind = dispatch_type; e.rd = dispatch_rd;
            e.pred = dispatch_pred_taken; e.rdy = dispatch_ready;
            e.val = dispatch_value; e.tkn = dispatch_pred_taken;
            exp_q.push_back(e);
            m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
        end
    endtask

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) model_reset();
        else        model_step();
    end

    function automatic logic q_ready(input logic [3:0] id);
        foreach (exp_q[i]) if (exp_q[i].id == id && exp_q[i].rdy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] q_value(input logic [3:0] id);
        foreach (exp_q[i]) if (exp_q[i].id == id) return exp_q[i].val;
        return '0;
    endfunction

    // scoreboard compare, away from the active edge
    always @(negedge clk_in) begin
        chk("dispatch_id", dispatch_id, m_tail);
        chk("has_no_vacancy", has_no_vacancy, exp_q.size() == 15);
        chk("commit_reg_valid", commit_reg_valid, m_reg_v);
        chk("commit_store_valid", commit_store_valid, m_store_v);
        chk("commit_rob_id", commit_rob_id, m_rid);
        if (!m_store_v) begin
            chk("commit_rd", commit_rd, m_rd);
            chk("commit_value", commit_value, m_val);
        end
        chk("flush_out", flush_out, m_flush);
        if (m_flush) chk("flush_pc", flush_pc, m_flush_pc);
        chk("query_j_ready", query_j_ready, q_ready(query_j_id));
        chk("query_k_ready", query_k_ready, q_ready(query_k_id));
        if (q_ready(query_j_id)) chk("query_j_value", query_j_value, q_value(query_j_id));
        if (q_ready(query_k_id)) chk("query_k_value", query_k_value, q_value(query_k_id));
    end

    // driver tasks
    task automatic idle();
        dispatch_valid = 1'b0; dispatch_type = 2'd0; dispatch_rd = '0;
        dispatch_pred_taken = 1'b0; dispatch_ready = 1'b0; dispatch_value = '0;
        query_j_id = '0; query_k_id = '0;
        cdb_alu_rob_id = '0; cdb_alu_value = '0;
        cdb_mem_rob_id = '0; cdb_mem_value = '0;
        bcu_rob_id = '0; bcu_taken = 1'b0; bcu_value = '0;
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                        input logic rdy, input logic [31:0] v);
        dispatch_valid = 1'b1; dispatch_type = t; dispatch_rd = rd;
        dispatch_pred_taken = pred; dispatch_ready = rdy; dispatch_value = v;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle();
        cyc();
        cyc();
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        do_reset();
        chk("rst_dispatch_id", dispatch_id, 1);
        chk("rst_commit_reg_valid", commit_reg_valid, 0);
        chk("rst_flush_out", flush_out, 0);

        // single REG entry completed by the ALU
        idle(); disp(2'd0, 5'd5, 1'b0, 1'b0, 32'h0); cyc();
        idle(); cdb_alu_rob_id = 4'd1; cdb_alu_value = 32'h1234; cyc();
        idle(); cyc();
        chk("t1_reg_valid", commit_reg_valid, 1);
        chk("t1_rd", commit_rd, 5);
        chk("t1_value", commit_value, 32'h1234);
        chk("t1_rob_id", commit_rob_id, 1);
        idle(); cyc();
        chk("t1_pulse", commit_reg_valid, 0);

        // fill, drop on full, wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle(); disp(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'h0); cyc();
        end
        chk("t2_full", has_no_vacancy, 1);
        chk("t2_tail_wrap", dispatch_id, 1);
        idle(); disp(2'd0, 5'd20, 1'b0, 1'b0, 32'h0); cyc();
        chk("t2_drop_full", has_no_vacancy, 1);
        chk("t2_drop_id", dispatch_id, 1);
        idle(); cdb_alu_rob_id = 4'd1; cdb_alu_value = 32'h100; cyc();
        idle(); cyc();
        chk("t2_commit_id", commit_rob_id, 1);
        chk("t2_freed", has_no_vacancy, 0);
        idle(); disp(2'd0, 5'd21, 1'b0, 1'b0, 32'h0); cyc();
        chk("t2_wrap_alloc", dispatch_id, 2);
        chk("t2_full_again", has_no_vacancy, 1);
        idle(); cdb_alu_rob_id = 4'd2; cdb_alu_value = 32'h200; disp(2'd0, 5'd22, 1'b0, 1'b0, 32'h0); cyc();
        idle(); disp(2'd0, 5'd23, 1'b0, 1'b0, 32'h0); cyc();
        chk("t2_same_cycle_commit", commit_rob_id, 2);
        chk("t2_same_cycle_drop", has_no_vacancy, 0);
        chk("t2_same_cycle_tail", dispatch_id, 2);

        // mispredicted branch flushes
        do_reset();
        idle(); disp(2'd1, 5'd0, 1'b0, 1'b0, 32'h0); cyc();
        idle(); disp(2'd0, 5'd9, 1'b0, 1'b0, 32'h0); cyc();
        idle(); bcu_rob_id = 4'd1; bcu_taken = 1'b1; bcu_value = 32'h80; cyc();
        idle(); cyc();
        chk("t3_flush", flush_out, 1);
        chk("t3_flush_pc", flush_pc, 32'h80);
        chk("t3_no_reg", commit_reg_valid, 0);
        idle(); disp(2'd0, 5'd3, 1'b0, 1'b1, 32'h77); query_j_id = 4'd2; cyc();
        chk("t3_flush_pulse", flush_out, 0);
        chk("t3_dispatch_id", dispatch_id, 1);
        chk("t3_vacancy", has_no_vacancy, 0);
        chk("t3_cleared", query_j_ready, 0);
        // correctly predicted branch retires silently
        idle(); disp(2'd1, 5'd0, 1'b1, 1'b0, 32'h0); cyc();
        idle(); bcu_rob_id = 4'd1; bcu_taken = 1'b1; bcu_value = 32'h90; cyc();
        idle(); cyc();
        chk("t3_silent_flush", flush_out, 0);
        chk("t3_silent_reg", commit_reg_valid, 0);
        // store and reserved type
        idle(); disp(2'd2, 5'd0, 1'b0, 1'b1, 32'h0); cyc();
        idle(); cyc();
        chk("t3_store_valid", commit_store_valid, 1);
        chk("t3_store_id", commit_rob_id, 2);
        idle(); disp(2'd3, 5'd17, 1'b0, 1'b1, 32'hDEAD); cyc();
        idle(); cyc();
        chk("t3_rsvd_reg", commit_reg_valid, 1);
        chk("t3_rsvd_rd", commit_rd, 17);
        chk("t3_rsvd_value", commit_value, 32'hDEAD);

        // out-of-order completion, in-order retire
        idle(); disp(2'd0, 5'd7, 1'b0, 1'b0, 32'h0); cyc();
        idle(); disp(2'd0, 5'd8, 1'b0, 1'b0, 32'h0); cyc();
        idle(); cdb_alu_rob_id = 4'd5; cdb_alu_value = 32'h22; cyc();
        idle(); cdb_alu_rob_id = 4'd0; cdb_alu_value = 32'hBAD; cyc();
        chk("t4_blocked", commit_reg_valid, 0);
        idle(); cdb_mem_rob_id = 4'd4; cdb_mem_value = 32'h11; cyc();
        idle(); cyc();
        chk("t4_first_id", commit_rob_id, 4);
        chk("t4_first_val", commit_value, 32'h11);
        idle(); cyc();
        chk("t4_second_id", commit_rob_id, 5);
        chk("t4_second_val", commit_value, 32'h22);

        // ALU and MEM collide on one id; no query forwarding
        idle(); disp(2'd0, 5'd9, 1'b0, 1'b0, 32'h0); cyc();
        idle(); cdb_alu_rob_id = 4'd6; cdb_alu_value = 32'hA;
        cdb_mem_rob_id = 4'd6; cdb_mem_value = 32'hB; query_j_id = 4'd6; #1;
        chk("t5_no_forward", query_j_ready, 0);
        cyc();
        chk("t5_ready", query_j_ready, 1);
        chk("t5_alu_wins", query_j_value, 32'hA);
        idle(); cyc();
        chk("t5_commit_val", commit_value, 32'hA);
        chk("t5_commit_id", commit_rob_id, 6);

        // three writebacks at once, then reset mid-commit
        for (int i = 0; i < 4; i++) begin
            idle(); disp(2'd0, 5'(i + 1), 1'b0, 1'b0, 32'h0); cyc();
        end
        idle(); cdb_alu_rob_id = 4'd7; cdb_alu_value = 32'h7;
        cdb_mem_rob_id = 4'd8; cdb_mem_value = 32'h8;
        bcu_rob_id = 4'd9; bcu_taken = 1'b0; bcu_value = 32'h9; cyc();
        idle(); query_j_id = 4'd9; query_k_id = 4'd8; cyc();
        chk("t6_commit_before_rst", commit_reg_valid, 1);
        chk("t6_q9", query_j_value, 32'h9);
        chk("t6_q8", query_k_value, 32'h8);
        #1 rst_in = 1'b1;
        #1;
        chk("t6_rst_reg_valid", commit_reg_valid, 0);
        chk("t6_rst_rob_id", commit_rob_id, 0);
        chk("t6_rst_value", commit_value, 0);
        chk("t6_rst_rd", commit_rd, 0);
        chk("t6_rst_store", commit_store_valid, 0);
        chk("t6_rst_flush", flush_out, 0);
        chk("t6_rst_flush_pc", flush_pc, 0);
        chk("t6_rst_dispatch_id", dispatch_id, 1);
        chk("t6_rst_query", query_j_ready, 0);
        cyc();
        rst_in = 1'b0;
        idle(); disp(2'd0, 5'd2, 1'b0, 1'b1, 32'h5); cyc();
        chk("t6_post_id", dispatch_id, 2);
        idle(); cyc();
        chk("t6_post_commit", commit_rob_id, 1);
        idle(); cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
